// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared definitions for the RTC multiplexed-bus master: FSM encoding,
// operation codes, RTC register map and phase-timer helpers.
package rtc_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_A_SETUP = 3'd1,
        ST_A_STB   = 3'd2,
        ST_A_HOLD  = 3'd3,
        ST_D_SETUP = 3'd4,
        ST_D_STB   = 3'd5,
        ST_D_HOLD  = 3'd6,
        ST_GAP     = 3'd7
    } rtc_state_e;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    // Phase counter width covers the 1..255 cycle range of both timing parameters.
    localparam int unsigned TMR_W = 8;

    // RTC register map
    localparam logic [7:0] RTC_REG_SEC     = 8'd33;
    localparam logic [7:0] RTC_REG_MIN     = 8'd34;
    localparam logic [7:0] RTC_REG_HOUR    = 8'd35;
    localparam logic [7:0] RTC_REG_DAY     = 8'd36;
    localparam logic [7:0] RTC_REG_MONTH   = 8'd37;
    localparam logic [7:0] RTC_REG_YEAR    = 8'd38;
    localparam logic [7:0] RTC_REG_TMR_LO  = 8'h41;
    localparam logic [7:0] RTC_REG_TMR_MID = 8'h42;
    localparam logic [7:0] RTC_REG_TMR_HI  = 8'h43;
    localparam logic [7:0] RTC_REG_CMD     = 8'hF0;

    // A phase of N cycles loads the down-counter with N-1 so it expires on the Nth cycle.
    function automatic logic [TMR_W-1:0] phase_reload(input int unsigned cycles);
        return TMR_W'(cycles - 32'd1);
    endfunction

    // Successor of the five fixed-length bus sub-phases that precede D_HOLD.
    function automatic rtc_state_e next_phase(input rtc_state_e s);
        case (s)
            ST_A_SETUP: return ST_A_STB;
            ST_A_STB:   return ST_A_HOLD;
            ST_A_HOLD:  return ST_D_SETUP;
            ST_D_SETUP: return ST_D_STB;
            ST_D_STB:   return ST_D_HOLD;
            default:    return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Loadable down-counter that times each bus sub-phase; o_tc flags the last
// cycle of the current phase.
module rtc_phase_timer
    import rtc_bus_ctrl_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Reload on request, otherwise count down and rest at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Bus master for the external RTC multiplexed address/data bus. Each accepted
// CPU access runs address setup/strobe/hold, data setup/strobe/hold and a
// chip-select recovery gap; read data is returned with a one-cycle done pulse.
module rtc_bus_ctrl
    import rtc_bus_ctrl_pkg::*;
#(
    parameter int unsigned T_PH  = 10,
    parameter int unsigned T_GAP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       actRTC,
    input  logic [7:0] dir,
    input  logic       wr_stb,
    input  logic       rd_stb,
    input  logic [7:0] dato_wr,
    output logic [7:0] dato_rd,
    output logic       busy,
    output logic       done,
    output logic       rtc_cs_n,
    output logic       rtc_a_d,
    output logic       rtc_wr_n,
    output logic       rtc_rd_n,
    output logic [7:0] rtc_ad_out,
    output logic       rtc_ad_oe,
    input  logic [7:0] rtc_ad_in
);

    localparam logic [TMR_W-1:0] PH_RELOAD  = phase_reload(T_PH);
    localparam logic [TMR_W-1:0] GAP_RELOAD = phase_reload(T_GAP);

    rtc_state_e       r_state;
    rtc_state_e       w_state_nxt;
    logic             r_op;
    logic [7:0]       r_addr;
    logic [7:0]       r_data;
    logic [7:0]       r_rd_cap;
    logic             w_accept;
    logic             w_tc;
    logic             w_load;
    logic [TMR_W-1:0] w_load_val;
    logic             w_op;
    logic [7:0]       w_addr;
    logic [7:0]       w_data;

    // Requests are only taken from IDLE; write wins when both strobes arrive.
    assign w_accept = (r_state == ST_IDLE) && actRTC && (wr_stb || rd_stb);
    // Request fields as seen by the next state: fresh inputs on accept, latched copy otherwise.
    assign w_op     = w_accept ? (wr_stb ? OP_WR : OP_RD) : r_op;
    assign w_addr   = w_accept ? dir : r_addr;
    assign w_data   = w_accept ? dato_wr : r_data;

    rtc_phase_timer #(.W(TMR_W)) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    // Next state and phase-counter reload on every state change.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        case (r_state)
            ST_IDLE: begin
                w_load = 1'b1;
                if (w_accept) begin
                    w_state_nxt = ST_A_SETUP;
                    w_load_val  = PH_RELOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_load_val  = '0;
                end
            end
            ST_A_SETUP, ST_A_STB, ST_A_HOLD, ST_D_SETUP, ST_D_STB: begin
                if (w_tc) begin
                    w_state_nxt = next_phase(r_state);
                    w_load      = 1'b1;
                    w_load_val  = PH_RELOAD;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_D_HOLD: begin
                if (w_tc) begin
                    w_state_nxt = ST_GAP;
                    w_load      = 1'b1;
                    w_load_val  = GAP_RELOAD;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_GAP: begin
                if (w_tc) begin
                    w_state_nxt = ST_IDLE;
                    w_load      = 1'b1;
                    w_load_val  = '0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_load      = 1'b1;
                w_load_val  = '0;
            end
        endcase
    end

    // FSM state, latched request, read capture and registered bus/CPU outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_RD;
            r_addr     <= 8'h00;
            r_data     <= 8'h00;
            r_rd_cap   <= 8'h00;
            dato_rd    <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            rtc_cs_n   <= 1'b1;
            rtc_a_d    <= 1'b0;
            rtc_wr_n   <= 1'b1;
            rtc_rd_n   <= 1'b1;
            rtc_ad_out <= 8'h00;
            rtc_ad_oe  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op;
            r_addr  <= w_addr;
            r_data  <= w_data;
            // Sample the pad on the final read-strobe cycle, while rd_n is still low.
            if ((r_state == ST_D_STB) && w_tc && (r_op == OP_RD)) begin
                r_rd_cap <= rtc_ad_in;
            end else begin
                r_rd_cap <= r_rd_cap;
            end
            // Read data becomes visible together with done; writes leave it untouched.
            if ((r_state == ST_D_HOLD) && w_tc && (r_op == OP_RD)) begin
                dato_rd <= r_rd_cap;
            end else begin
                dato_rd <= dato_rd;
            end
            busy <= (w_state_nxt != ST_IDLE);
            done <= (r_state == ST_D_HOLD) && w_tc;
            case (w_state_nxt)
                ST_A_SETUP, ST_A_HOLD: begin
                    rtc_cs_n   <= 1'b0;
                    rtc_a_d    <= 1'b0;
                    rtc_wr_n   <= 1'b1;
                    rtc_rd_n   <= 1'b1;
                    rtc_ad_out <= w_addr;
                    rtc_ad_oe  <= 1'b1;
                end
                ST_A_STB: begin
                    rtc_cs_n   <= 1'b0;
                    rtc_a_d    <= 1'b0;
                    rtc_wr_n   <= 1'b0;
                    rtc_rd_n   <= 1'b1;
                    rtc_ad_out <= w_addr;
                    rtc_ad_oe  <= 1'b1;
                end
                ST_D_SETUP, ST_D_HOLD: begin
                    rtc_cs_n   <= 1'b0;
                    rtc_a_d    <= 1'b1;
                    rtc_wr_n   <= 1'b1;
                    rtc_rd_n   <= 1'b1;
                    rtc_ad_out <= (w_op == OP_WR) ? w_data : 8'h00;
                    rtc_ad_oe  <= (w_op == OP_WR);
                end
                ST_D_STB: begin
                    rtc_cs_n   <= 1'b0;
                    rtc_a_d    <= 1'b1;
                    rtc_wr_n   <= (w_op != OP_WR);
                    rtc_rd_n   <= (w_op != OP_RD);
                    rtc_ad_out <= (w_op == OP_WR) ? w_data : 8'h00;
                    rtc_ad_oe  <= (w_op == OP_WR);
                end
                default: begin
                    rtc_cs_n   <= 1'b1;
                    rtc_a_d    <= 1'b0;
                    rtc_wr_n   <= 1'b1;
                    rtc_rd_n   <= 1'b1;
                    rtc_ad_out <= 8'h00;
                    rtc_ad_oe  <= 1'b0;
                end
            endcase
        end
    end

endmodule
